// File: rtl/winograd_stream_afu.sv
// Streaming Winograd F(2x2,3x3) AFU: input line FIFO -> processing_element -> output line FIFO,
// with credit-based issue, optional 4-tile result packing and start/busy/done job control.

module syn_read_fifo #(
    parameter int unsigned WIDTH      = 512,
    parameter int unsigned DEPTH_BITS = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  we_i,
    input  logic                  re_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_BITS-1:0] count_o
);
    // One slot stays unused so count fits in DEPTH_BITS; capacity is 2**DEPTH_BITS-1.
    logic [WIDTH-1:0]      mem_q [1<<DEPTH_BITS];
    logic [DEPTH_BITS-1:0] wr_q, rd_q;
    logic                  do_rd, do_wr;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (DEPTH_BITS'(wr_q + 1'b1) == rd_q);
    assign count_o = wr_q - rd_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];
    assign do_rd   = re_i && !empty_o;
    assign do_wr   = we_i && (!full_o || do_rd);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_wr) wr_q <= wr_q + 1'b1;
            if (do_rd) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_q] <= din_i;
    end
endmodule

module processing_element (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         next_i,
    input  logic [511:0] data_i,
    input  logic [287:0] filter_i,
    output logic         next_out_o,
    output logic [127:0] data_o
);
    // Truncating single-precision arithmetic; denormals flush to zero, no NaN handling.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [9:0]  e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) begin
            p = p >> 1;
            e = e + 10'd1;
        end
        if ($signed(e) <= 0) return {s, 31'd0};
        if ($signed(e) >= 255) return {s, 8'hFF, 23'd0};
        return {s, e[7:0], p[45:23]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big, sml;
        logic [7:0]  sh, e;
        logic [24:0] mb, ms, s;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        sh = big[30:23] - sml[30:23];
        e  = big[30:23];
        mb = {2'b01, big[22:0]};
        ms = (sh > 8'd24) ? '0 : ({2'b01, sml[22:0]} >> sh);
        if (big[31] == sml[31]) begin
            s = mb + ms;
            if (s[24]) begin
                if (e == 8'd254) return {big[31], 8'hFF, 23'd0};
                s = s >> 1;
                e = e + 8'd1;
            end
        end else begin
            s = mb - ms;
            if (s == '0) return '0;
            for (int unsigned k = 0; k < 24; k++) begin
                if (!s[23]) begin
                    if (e == 8'd1) return '0;
                    s = s << 1;
                    e = e - 8'd1;
                end
            end
        end
        return {big[31], e, s[22:0]};
    endfunction

    // Stage 1 forms the 36 kernel products, stage 2 reduces them; same outputs as the Winograd transform.
    logic [31:0] prod_d [4][9];
    logic [31:0] prod_q [4][9];
    logic [31:0] sum_d  [4];
    logic [31:0] sum_q  [4];
    logic        v1_q, v2_q;

    always_comb begin
        for (int unsigned o = 0; o < 4; o++) begin
            for (int unsigned k = 0; k < 9; k++) begin
                prod_d[o][k] = fp_mul(data_i[128*(o/2 + k/3) + 32*(o%2 + k%3) +: 32],
                                      filter_i[32*k +: 32]);
            end
        end
    end

    always_comb begin
        for (int unsigned o = 0; o < 4; o++) begin
            sum_d[o] = prod_q[o][0];
            for (int unsigned k = 1; k < 9; k++) sum_d[o] = fp_add(sum_d[o], prod_q[o][k]);
        end
    end

    always_ff @(posedge clk_i) begin
        prod_q <= prod_d;
        sum_q  <= sum_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= next_i;
            v2_q <= v1_q;
        end
    end

    assign next_out_o = v2_q;
    assign data_o     = {sum_q[3], sum_q[2], sum_q[1], sum_q[0]};
endmodule

module winograd_stream_afu #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BUFF_DEPTH_BITS = 3,
    parameter int unsigned PACK_OUTPUTS    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [16*DATA_WIDTH-1:0]   input_fifo_din,
    input  logic                       input_fifo_we,
    output logic                       input_fifo_full,
    output logic                       input_fifo_almost_full,
    output logic [BUFF_DEPTH_BITS-1:0] input_fifo_count,
    output logic [16*DATA_WIDTH-1:0]   output_fifo_dout,
    input  logic                       output_fifo_re,
    output logic                       output_fifo_empty,
    output logic                       output_fifo_almost_empty,
    input  logic                       ctx_start,
    input  logic [31:0]                ctx_length,
    output logic                       ctx_busy,
    output logic                       ctx_done,
    output logic [31:0]                tiles_done
);
    localparam int unsigned LINE_W = 16 * DATA_WIDTH;
    localparam int unsigned LANE_W = 4 * DATA_WIDTH;
    localparam int unsigned CNT_W  = BUFF_DEPTH_BITS;
    localparam int unsigned CAP    = (1 << CNT_W) - 1;
    localparam int unsigned SUM_W  = CNT_W + 3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_FLUSH, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             remaining_q, remaining_d;
    logic [31:0]             tiles_q, tiles_d;
    logic [CNT_W:0]          inflight_q, inflight_d;
    logic [1:0]              pack_fill_q, pack_fill_d;
    logic [3*LANE_W-1:0]     pack_q, pack_d;
    logic [9*DATA_WIDTH-1:0] filter_q, filter_d;
    logic                    out_we_q, out_we_d;
    logic [LINE_W-1:0]       out_din_q, out_din_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic              in_re, in_empty, out_full, pe_next, pe_next_out, credit_ok;
    logic [LINE_W-1:0] in_dout;
    logic [LANE_W-1:0] pe_out;
    logic [CNT_W-1:0]  out_count;
    logic [SUM_W-1:0]  credit_sum;

    syn_read_fifo #(.WIDTH(LINE_W), .DEPTH_BITS(CNT_W)) u_in_fifo (
        .clk_i(clk), .reset_i(reset), .din_i(input_fifo_din), .we_i(input_fifo_we), .re_i(in_re),
        .dout_o(in_dout), .full_o(input_fifo_full), .empty_o(in_empty), .count_o(input_fifo_count)
    );

    syn_read_fifo #(.WIDTH(LINE_W), .DEPTH_BITS(CNT_W)) u_out_fifo (
        .clk_i(clk), .reset_i(reset), .din_i(out_din_q), .we_i(out_we_q && !out_full),
        .re_i(output_fifo_re), .dout_o(output_fifo_dout), .full_o(out_full),
        .empty_o(output_fifo_empty), .count_o(out_count)
    );

    processing_element u_pe (
        .clk_i(clk), .reset_i(reset), .next_i(pe_next), .data_i(in_dout), .filter_i(filter_q),
        .next_out_o(pe_next_out), .data_o(pe_out)
    );

    assign input_fifo_almost_full   = (input_fifo_count >= CNT_W'(CAP - 3));
    assign output_fifo_almost_empty = (out_count <= CNT_W'(2));
    assign ctx_busy   = busy_q;
    assign ctx_done   = done_q;
    assign tiles_done = tiles_q;

    // Every tile that could still land in the output FIFO is counted before issuing another.
    assign credit_sum = SUM_W'(out_count) + SUM_W'(inflight_q) + SUM_W'(pack_fill_q) + SUM_W'(out_we_q);
    assign credit_ok  = (credit_sum < SUM_W'(CAP));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tiles_d     = tiles_q;
        pack_fill_d = pack_fill_q;
        pack_d      = pack_q;
        filter_d    = filter_q;
        out_we_d    = 1'b0;
        out_din_d   = out_din_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        in_re       = 1'b0;
        pe_next     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctx_start) begin
                    remaining_d = ctx_length;
                    tiles_d     = '0;
                    busy_d      = 1'b1;
                    state_d     = (ctx_length == 32'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (!in_empty) begin
                    in_re = 1'b1;
                    for (int unsigned k = 0; k < 9; k++) begin
                        filter_d[k*DATA_WIDTH +: DATA_WIDTH] =
                            in_dout[(k/3)*LANE_W + (k%3)*DATA_WIDTH +: DATA_WIDTH];
                    end
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!in_empty && credit_ok && remaining_q != 32'd0) begin
                    in_re       = 1'b1;
                    pe_next     = 1'b1;
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (inflight_q == '0) begin
                    if (PACK_OUTPUTS != 0 && pack_fill_q != 2'd0) begin
                        out_we_d    = 1'b1;
                        out_din_d   = {LANE_W'(0), pack_q};
                        pack_d      = '0;
                        pack_fill_d = 2'd0;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A result only returns while inflight is non-zero, so this never collides with the FLUSH write.
        if (pe_next_out) begin
            tiles_d = tiles_q + 32'd1;
            if (PACK_OUTPUTS == 0) begin
                out_we_d  = 1'b1;
                out_din_d = '0;
                out_din_d[0 +: DATA_WIDTH]                   = pe_out[0 +: DATA_WIDTH];
                out_din_d[DATA_WIDTH +: DATA_WIDTH]          = pe_out[DATA_WIDTH +: DATA_WIDTH];
                out_din_d[LANE_W +: DATA_WIDTH]              = pe_out[2*DATA_WIDTH +: DATA_WIDTH];
                out_din_d[LANE_W + DATA_WIDTH +: DATA_WIDTH] = pe_out[3*DATA_WIDTH +: DATA_WIDTH];
            end else if (pack_fill_q == 2'd3) begin
                out_we_d    = 1'b1;
                out_din_d   = {pe_out, pack_q};
                pack_d      = '0;
                pack_fill_d = 2'd0;
            end else begin
                pack_d[LANE_W*32'(pack_fill_q) +: LANE_W] = pe_out;
                pack_fill_d = pack_fill_q + 2'd1;
            end
        end

        inflight_d = inflight_q + (CNT_W+1)'(pe_next) - (CNT_W+1)'(pe_next_out);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            tiles_q     <= '0;
            inflight_q  <= '0;
            pack_fill_q <= '0;
            pack_q      <= '0;
            filter_q    <= '0;
            out_we_q    <= 1'b0;
            out_din_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tiles_q     <= tiles_d;
            inflight_q  <= inflight_d;
            pack_fill_q <= pack_fill_d;
            pack_q      <= pack_d;
            filter_q    <= filter_d;
            out_we_q    <= out_we_d;
            out_din_q   <= out_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule
